// File: rtl/conv_pkg.sv
// Shared types and limits for the convolution front-end: pixel format, image bounds
// and the line-buffer sequencer state encoding.
package conv_pkg;

    localparam int PIXEL_W     = 8;
    localparam int IMAGE_MAX_W = 16;
    localparam int IMAGE_MAX_H = 16;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_STEADY = 2'd2
    } lb_state_t;

endpackage

// File: rtl/conv_cntrl_lb_seq.sv
// Line-buffer sequencer: turns a framed pixel stream into push/pop controls, tracks
// pixel position and learns the line width from the first line of each frame.
module conv_cntrl_lb_seq
    import conv_pkg::*;
#(
    parameter int KERNEL_N = 3
) (
    input  logic                           clk,
    input  logic                           arst,
    input  logic                           s_vld_i,
    input  logic [PIXEL_W-1:0]             s_dat_i,
    input  logic                           s_sof_i,
    input  logic                           s_eol_i,
    output logic                           s_rdy_o,
    input  logic                           m_rdy_i,
    output logic                           push_o,
    output logic                           pop_o,
    output logic                           sof_o,
    output logic                           eol_o,
    output logic [PIXEL_W-1:0]             dat_o,
    output logic                           win_vld_o,
    output logic [$clog2(IMAGE_MAX_H)-1:0] row_o,
    output logic [$clog2(IMAGE_MAX_W)-1:0] col_o,
    output logic                           err_o
);

    localparam int ROW_W = $clog2(IMAGE_MAX_H);
    localparam int COL_W = $clog2(IMAGE_MAX_W);
    localparam logic [COL_W:0] ONE_W = (COL_W+1)'(1);

    lb_state_t        state, state_nxt;
    logic [ROW_W-1:0] pos_row, pos_row_nxt;
    logic [COL_W-1:0] pos_col, pos_col_nxt;
    logic [COL_W:0]   width, width_nxt;

    logic accept, line_last, col_at_max, row_at_max, in_window;

    logic             push_d, pop_d, sof_d, eol_d, win_d, err_d;
    pixel_t           dat_d;
    logic [ROW_W-1:0] row_d;
    logic [COL_W-1:0] col_d;

    assign s_rdy_o    = m_rdy_i;
    assign accept     = s_vld_i & m_rdy_i;
    assign line_last  = ({1'b0, pos_col} == (width - ONE_W));
    assign col_at_max = (pos_col == COL_W'(IMAGE_MAX_W-1));
    assign row_at_max = (pos_row == ROW_W'(IMAGE_MAX_H-1));
    assign in_window  = (pos_row >= ROW_W'(KERNEL_N-1)) && (pos_col >= COL_W'(KERNEL_N-1));

    // pos_row/pos_col always hold the position the next accepted beat will occupy
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= ST_IDLE;
            pos_row <= '0;
            pos_col <= '0;
            width   <= '0;
        end else begin
            state   <= state_nxt;
            pos_row <= pos_row_nxt;
            pos_col <= pos_col_nxt;
            width   <= width_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pos_row_nxt = pos_row;
        pos_col_nxt = pos_col;
        width_nxt   = width;
        if (accept) begin
            if (s_sof_i) begin
                if (s_eol_i) begin
                    state_nxt   = ST_STEADY;
                    width_nxt   = ONE_W;
                    pos_row_nxt = ROW_W'(1);
                    pos_col_nxt = '0;
                end else begin
                    state_nxt   = ST_FIRST;
                    pos_row_nxt = '0;
                    pos_col_nxt = COL_W'(1);
                end
            end else begin
                unique case (state)
                    ST_IDLE: ;
                    ST_FIRST: begin
                        if (s_eol_i) begin
                            state_nxt   = ST_STEADY;
                            width_nxt   = {1'b0, pos_col} + ONE_W;
                            pos_row_nxt = ROW_W'(1);
                            pos_col_nxt = '0;
                        end else if (col_at_max) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            pos_col_nxt = pos_col + COL_W'(1);
                        end
                    end
                    ST_STEADY: begin
                        if (s_eol_i && line_last) begin
                            pos_col_nxt = '0;
                            pos_row_nxt = row_at_max ? pos_row : pos_row + ROW_W'(1);
                        end else if (s_eol_i || line_last) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            pos_col_nxt = pos_col + COL_W'(1);
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    // A line-length disagreement in STEADY still closes the line with eol so the buffers stay aligned
    always_comb begin
        push_d = 1'b0;
        pop_d  = 1'b0;
        sof_d  = 1'b0;
        eol_d  = 1'b0;
        win_d  = 1'b0;
        err_d  = 1'b0;
        dat_d  = dat_o;
        row_d  = row_o;
        col_d  = col_o;
        if (accept) begin
            if (s_sof_i) begin
                push_d = 1'b1;
                sof_d  = 1'b1;
                eol_d  = s_eol_i;
                err_d  = (state != ST_IDLE) && (pos_col != '0);
                dat_d  = s_dat_i;
                row_d  = '0;
                col_d  = '0;
            end else if (state == ST_FIRST) begin
                push_d = 1'b1;
                eol_d  = s_eol_i;
                err_d  = !s_eol_i && col_at_max;
                dat_d  = s_dat_i;
                row_d  = pos_row;
                col_d  = pos_col;
            end else if (state == ST_STEADY) begin
                push_d = 1'b1;
                pop_d  = 1'b1;
                win_d  = in_window;
                eol_d  = s_eol_i | line_last;
                err_d  = s_eol_i ^ line_last;
                dat_d  = s_dat_i;
                row_d  = pos_row;
                col_d  = pos_col;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            push_o    <= 1'b0;
            pop_o     <= 1'b0;
            sof_o     <= 1'b0;
            eol_o     <= 1'b0;
            win_vld_o <= 1'b0;
            err_o     <= 1'b0;
            dat_o     <= '0;
            row_o     <= '0;
            col_o     <= '0;
        end else begin
            push_o    <= push_d;
            pop_o     <= pop_d;
            sof_o     <= sof_d;
            eol_o     <= eol_d;
            win_vld_o <= win_d;
            err_o     <= err_d;
            dat_o     <= dat_d;
            row_o     <= row_d;
            col_o     <= col_d;
        end
    end

endmodule

// File: tb/tb_conv_cntrl_lb_seq.sv
// Self-checking bench for conv_cntrl_lb_seq: a directed vector table, framed scenarios
// and a randomized stream, all compared against a frame-level reference model.
module tb_conv_cntrl_lb_seq;
    import conv_pkg::*;

    localparam int K  = 3;
    localparam int RW = $clog2(IMAGE_MAX_H);
    localparam int CW = $clog2(IMAGE_MAX_W);

    typedef struct packed {
        logic push, pop, sof, eol, win, err;
        logic [PIXEL_W-1:0] dat;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
    } exp_t;

    typedef struct packed {
        logic vld, sof, eol, rdy;
        logic [PIXEL_W-1:0] dat;
        exp_t e;
    } vec_t;

    logic clk, arst, s_vld_i, s_sof_i, s_eol_i, s_rdy_o, m_rdy_i;
    logic [PIXEL_W-1:0] s_dat_i, dat_o;
    logic push_o, pop_o, sof_o, eol_o, win_vld_o, err_o;
    logic [RW-1:0] row_o;
    logic [CW-1:0] col_o;

    conv_cntrl_lb_seq #(.KERNEL_N(K)) dut (
        .clk(clk), .arst(arst),
        .s_vld_i(s_vld_i), .s_dat_i(s_dat_i), .s_sof_i(s_sof_i), .s_eol_i(s_eol_i),
        .s_rdy_o(s_rdy_o), .m_rdy_i(m_rdy_i),
        .push_o(push_o), .pop_o(pop_o), .sof_o(sof_o), .eol_o(eol_o),
        .dat_o(dat_o), .win_vld_o(win_vld_o), .row_o(row_o), .col_o(col_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int win_seen = 0;

    // Reference model: m_width is -1 outside a frame, 0 while the first line is
    // still being measured, otherwise the learned line length.
    int m_width, m_row, m_col;
    logic [PIXEL_W-1:0] e_dat;
    int e_row, e_col;

    vec_t vecs[$];

    function automatic exp_t mk_exp(logic push, logic pop, logic sof, logic eol, logic win,
                                    logic err, int dat, int row, int col);
        exp_t e;
        e.push = push; e.pop = pop; e.sof = sof; e.eol = eol; e.win = win; e.err = err;
        e.dat = PIXEL_W'(dat);
        e.row = RW'(row);
        e.col = CW'(col);
        return e;
    endfunction

    function automatic exp_t sample_dut();
        exp_t a;
        a.push = push_o; a.pop = pop_o; a.sof = sof_o; a.eol = eol_o;
        a.win = win_vld_o; a.err = err_o; a.dat = dat_o; a.row = row_o; a.col = col_o;
        return a;
    endfunction

    task automatic add_vec(logic vld, logic sof, logic eol, logic rdy, int dat, exp_t e);
        vec_t v;
        v.vld = vld; v.sof = sof; v.eol = eol; v.rdy = rdy; v.dat = PIXEL_W'(dat); v.e = e;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(string name, exp_t e);
        exp_t a;
        a = sample_dut();
        checks++;
        if (a === e) passes++;
        else $display("[TB] FAIL %s: got push=%0b pop=%0b sof=%0b eol=%0b win=%0b err=%0b dat=%0h row=%0d col=%0d, expected push=%0b pop=%0b sof=%0b eol=%0b win=%0b err=%0b dat=%0h row=%0d col=%0d",
                      name, a.push, a.pop, a.sof, a.eol, a.win, a.err, a.dat, a.row, a.col,
                      e.push, e.pop, e.sof, e.eol, e.win, e.err, e.dat, e.row, e.col);
    endtask

    task automatic checkValue(string name, int got, int want);
        checks++;
        if (got == want) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    // Entered at posedge+1; leaves at the following posedge+1 with outputs settled.
    task automatic applyStimulus(logic vld, logic sof, logic eol, logic rdy, logic [PIXEL_W-1:0] dat);
        s_vld_i = vld; s_sof_i = sof; s_eol_i = eol; m_rdy_i = rdy; s_dat_i = dat;
        #1;
        checkValue("s_rdy_tracks_m_rdy", int'(s_rdy_o), int'(rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_width = -1; m_row = 0; m_col = 0;
        e_dat = '0; e_row = 0; e_col = 0;
    endtask

    task automatic model_beat(logic acc, logic sof, logic eol, logic [PIXEL_W-1:0] dat, output exp_t e);
        logic last;
        e = mk_exp(0, 0, 0, 0, 0, 0, int'(e_dat), e_row, e_col);
        if (acc) begin
            if (sof) begin
                e = mk_exp(1, 0, 1, eol, 0, (m_width != -1) && (m_col != 0), int'(dat), 0, 0);
                if (eol) begin m_width = 1; m_row = 1; m_col = 0; end
                else     begin m_width = 0; m_row = 0; m_col = 1; end
            end else if (m_width == 0) begin
                e = mk_exp(1, 0, 0, eol, 0, !eol && (m_col == IMAGE_MAX_W-1), int'(dat), m_row, m_col);
                if (eol) begin m_width = m_col + 1; m_row = 1; m_col = 0; end
                else if (m_col == IMAGE_MAX_W-1) m_width = -1;
                else m_col++;
            end else if (m_width > 0) begin
                last = (m_col == m_width - 1);
                e = mk_exp(1, 1, 0, eol || last, (m_row >= K-1) && (m_col >= K-1),
                           eol != last, int'(dat), m_row, m_col);
                if (eol && last) begin
                    m_col = 0;
                    if (m_row < IMAGE_MAX_H-1) m_row++;
                end else if (eol || last) m_width = -1;
                else m_col++;
            end
        end
        e_dat = e.dat; e_row = int'(e.row); e_col = int'(e.col);
    endtask

    task automatic step_model(logic vld, logic sof, logic eol, logic rdy, logic [PIXEL_W-1:0] dat, string name);
        exp_t e;
        applyStimulus(vld, sof, eol, rdy, dat);
        model_beat(vld && rdy, sof, eol, dat, e);
        checkOutput(name, e);
        if (win_vld_o) win_seen++;
    endtask

    task automatic send_frame(int w, int h, bit gaps, int base, string name);
        logic gv, gr;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                if (gaps && $urandom_range(0, 1) == 1) begin
                    gv = 1'($urandom_range(0, 1));
                    gr = gv ? 1'b0 : 1'($urandom_range(0, 1));
                    step_model(gv, 1'($urandom_range(0, 1)), 1'b0, gr, 8'hEE, {name, "_gap"});
                end
                step_model(1'b1, (r == 0) && (c == 0), c == w-1, 1'b1, PIXEL_W'(base + r*w + c), name);
            end
    endtask

    task automatic pulse_reset();
        s_vld_i = 1'b0; s_sof_i = 1'b0; s_eol_i = 1'b0;
        arst = 1'b1;
        #1;
        checkOutput("async_reset_clears", mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        arst = 1'b0;
        model_reset();
    endtask

    task automatic random_stream(int n);
        int gw, gc;
        logic vld, rdy, sof, eol;
        gw = 3; gc = 0;
        for (int i = 0; i < n; i++) begin
            vld = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            sof = (i == 0) || ($urandom_range(0, 39) == 0);
            eol = (gc == gw-1) ^ ($urandom_range(0, 29) == 0);
            if (i == 0) begin vld = 1'b1; rdy = 1'b1; end
            step_model(vld, sof, eol, rdy, PIXEL_W'($urandom), "random");
            if (vld && rdy) begin
                if (sof) begin
                    gw = $urandom_range(1, 6);
                    gc = eol ? 0 : 1;
                end else gc = eol ? 0 : gc + 1;
                if (gc >= gw) gc = 0;
            end
        end
    endtask

    initial begin
        vec_t v;
        arst = 1'b1; s_vld_i = 1'b0; s_sof_i = 1'b0; s_eol_i = 1'b0;
        m_rdy_i = 1'b0; s_dat_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0));
        arst = 1'b0;

        // Discard before sof, 1-pixel lines, STEADY overrun, then a mid-line sof restart
        add_vec(1, 0, 0, 1, 'h11, mk_exp(0, 0, 0, 0, 0, 0, 'h00, 0, 0));
        add_vec(1, 0, 0, 1, 'h12, mk_exp(0, 0, 0, 0, 0, 0, 'h00, 0, 0));
        add_vec(1, 1, 1, 1, 'h13, mk_exp(1, 0, 1, 1, 0, 0, 'h13, 0, 0));
        add_vec(1, 0, 1, 1, 'h14, mk_exp(1, 1, 0, 1, 0, 0, 'h14, 1, 0));
        add_vec(1, 0, 1, 1, 'h15, mk_exp(1, 1, 0, 1, 0, 0, 'h15, 2, 0));
        add_vec(1, 0, 0, 1, 'h16, mk_exp(1, 1, 0, 1, 0, 1, 'h16, 3, 0));
        add_vec(1, 0, 0, 1, 'h17, mk_exp(0, 0, 0, 0, 0, 0, 'h16, 3, 0));
        add_vec(1, 1, 0, 1, 'h20, mk_exp(1, 0, 1, 0, 0, 0, 'h20, 0, 0));
        add_vec(1, 0, 0, 1, 'h21, mk_exp(1, 0, 0, 0, 0, 0, 'h21, 0, 1));
        add_vec(1, 0, 1, 1, 'h22, mk_exp(1, 0, 0, 1, 0, 0, 'h22, 0, 2));
        add_vec(1, 0, 0, 1, 'h23, mk_exp(1, 1, 0, 0, 0, 0, 'h23, 1, 0));
        add_vec(1, 0, 0, 1, 'h24, mk_exp(1, 1, 0, 0, 0, 0, 'h24, 1, 1));
        add_vec(1, 1, 0, 1, 'h25, mk_exp(1, 0, 1, 0, 0, 1, 'h25, 0, 0));
        add_vec(0, 0, 0, 1, 'h26, mk_exp(0, 0, 0, 0, 0, 0, 'h25, 0, 0));
        add_vec(1, 1, 0, 0, 'h27, mk_exp(0, 0, 0, 0, 0, 0, 'h25, 0, 0));
        add_vec(1, 0, 0, 1, 'h28, mk_exp(1, 0, 0, 0, 0, 0, 'h28, 0, 1));
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v.vld, v.sof, v.eol, v.rdy, v.dat);
            checkOutput($sformatf("vec%0d", i), v.e);
        end
        pulse_reset();

        win_seen = 0;
        send_frame(4, 4, 1'b0, 'h40, "frame4x4");
        checkValue("frame4x4_win_count", win_seen, 4);

        win_seen = 0;
        send_frame(4, 4, 1'b1, 'h40, "frame4x4_gaps");
        checkValue("frame4x4_gaps_win_count", win_seen, 4);

        // Short line in STEADY: error, forced eol, then stream ignored until next sof
        for (int i = 0; i < 11; i++)
            step_model(1'b1, i == 0, (i == 3) || (i == 7) || (i == 10), 1'b1, PIXEL_W'(i), "short_line");
        for (int i = 0; i < 3; i++)
            step_model(1'b1, 1'b0, i == 2, 1'b1, PIXEL_W'('h80 + i), "after_error");

        for (int i = 0; i < 10; i++)
            step_model(1'b1, i == 0, (i == 3) || (i == 7), 1'b1, PIXEL_W'('h90 + i), "pre_reset");
        pulse_reset();
        step_model(1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, "post_reset_no_sof");
        send_frame(3, 3, 1'b0, 'hB0, "post_reset_frame");

        for (int i = 0; i < IMAGE_MAX_W + 1; i++)
            step_model(1'b1, i == 0, 1'b0, 1'b1, PIXEL_W'('hC0 + i), "first_line_overflow");

        for (int i = 0; i < IMAGE_MAX_H + 4; i++)
            step_model(1'b1, i == 0, 1'b1, 1'b1, PIXEL_W'(i), "row_saturation");

        random_stream(600);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/conv_cntrl_lb_seq.md
CONV_CNTRL_LB_SEQ -- requirements
Module: conv_cntrl_lb_seq

Interface
REQ-001 The block SHALL have one parameter: KERNEL_N, default 3, kernel height/width in pixels (odd, 3..7).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: arst  input  1  asynchronous active-high reset.
REQ-005 Port: s_vld_i  input  1  upstream pixel valid.
REQ-006 Port: s_dat_i  input  conv_pkg::PIXEL_W  upstream pixel.
REQ-007 Port: s_sof_i  input  1  first pixel of frame, qualified by s_vld_i.
REQ-008 Port: s_eol_i  input  1  last pixel of line, qualified by s_vld_i.
REQ-009 Port: s_rdy_o  output  1  upstream ready; s_rdy_o = m_rdy_i (combinational).
REQ-010 Port: m_rdy_i  input  1  downstream datapath can accept a pixel.
REQ-011 Port: push_o, pop_o, sof_o, eol_o  output  1 each  line-buffer controls (registered).
REQ-012 Port: dat_o  output  conv_pkg::PIXEL_W  pixel to line buffers (registered).
REQ-013 Port: win_vld_o  output  1  a full KERNEL_N x KERNEL_N window is complete this cycle.
REQ-014 Port: row_o, col_o  output  clog2(IMAGE_MAX_H), clog2(IMAGE_MAX_W)  position of current pixel.
REQ-015 Port: err_o  output  1  single-cycle protocol-error pulse.

Function
REQ-016 A beat SHALL be accepted iff s_vld_i & s_rdy_o; all outputs SHALL reflect an accepted beat exactly one cycle later; with no accepted beat push_o, pop_o, sof_o, eol_o, win_vld_o, err_o SHALL be 0 and dat_o/row_o/col_o SHALL hold.
REQ-017 FSM states: IDLE, FIRST, STEADY.
REQ-018 IDLE: beats without s_sof_i SHALL be accepted and discarded (no push); beat with s_sof_i -> FIRST, push_o=1, sof_o=1, row=0, col=0.
REQ-019 FIRST: every beat SHALL push with pop_o=0; on s_eol_i the block SHALL latch width = col+1, assert eol_o, set row=1, col=0 -> STEADY.
REQ-020 STEADY: every beat SHALL assert push_o and pop_o; eol_o on s_eol_i; col SHALL increment, resetting to 0 and incrementing row (saturating at IMAGE_MAX_H-1) after eol.
REQ-021 win_vld_o SHALL be 1 iff the beat is accepted in STEADY with row >= KERNEL_N-1 and col >= KERNEL_N-1.
REQ-022 s_sof_i in FIRST or STEADY SHALL restart the frame exactly as REQ-018 and pulse err_o only if col != 0.
REQ-023 In STEADY, s_eol_i with col != width-1, or col reaching width-1 without s_eol_i, SHALL pulse err_o, force eol_o=1 and return to IDLE.
REQ-024 In FIRST, col reaching IMAGE_MAX_W-1 without s_eol_i SHALL pulse err_o and return to IDLE.
REQ-025 Simultaneous s_sof_i and s_eol_i (1-pixel line) SHALL give sof_o=eol_o=1, width=1, -> STEADY.
REQ-026 Counters SHALL be unsigned, no wrap; width register SHALL be clog2(IMAGE_MAX_W)+1 bits.

Reset
REQ-027 On arst: state=IDLE; all 1-bit outputs 0; dat_o, row_o, col_o, width 0.
REQ-028 Reset asserted mid-frame SHALL discard the frame; first post-reset beat needs s_sof_i.

Structure
REQ-029 IMAGE_MAX_H and the FSM state enum SHALL be added to conv_pkg beside pixel_t, PIXEL_W, IMAGE_MAX_W.
REQ-030 The block SHALL be a single module with no sub-modules; registers use the shared flop macros.

Verification
REQ-031 Width-4, 4-line frame, KERNEL_N=3, m_rdy_i=1: first line push only, then push+pop; win_vld_o on (r2,c2),(r2,c3),(r3,c2),(r3,c3) only.
REQ-032 Toggle m_rdy_i 50% on same frame: identical output sequence compressed to accepted beats, s_rdy_o tracks m_rdy_i same cycle.
REQ-033 Width-4 frame, line 2 eol at col 2: err_o one pulse, eol_o=1, state IDLE, next non-sof beats produce no push.
REQ-034 Pixels before sof, then sof+eol same beat: no push before sof; then sof_o=eol_o=1, width=1, next beat pop_o=1.
REQ-035 arst pulse at row 2 col 1, then new sof frame: all outputs 0 after reset, new frame starts row 0 col 0, no err_o.
REQ-036 sof at row 1 col 2: err_o=1, sof_o=1, row_o=0, col_o=0, pop_o=0.
